instr_encoder: RTL



---
 rtl/instr_encoder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and streams
// {instr, err} with its address through a 2-entry output FIFO.
package lib_pkg;

  typedef logic [3:0] op_type_t;

  localparam op_type_t OP_LUI     = 4'd0;
  localparam op_type_t OP_AUIPC   = 4'd1;
  localparam op_type_t OP_JAL     = 4'd2;
  localparam op_type_t OP_JALR    = 4'd3;
  localparam op_type_t OP_BRANCH  = 4'd4;
  localparam op_type_t OP_LOAD    = 4'd5;
  localparam op_type_t OP_STORE   = 4'd6;
  localparam op_type_t OP_OPIMM   = 4'd7;
  localparam op_type_t OP_OP      = 4'd8;
  localparam op_type_t OP_MISCMEM = 4'd9;
  localparam op_type_t OP_SYSTEM  = 4'd10;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

endpackage

module instr_encoder
  import lib_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_type_t          op_type,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ADDR_INC = 4;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

  logic [WORD_W-1:0] enc_instr_c;
  logic              enc_err_c;
  logic              i_range_ok_c;
  logic              b_range_ok_c;
  logic              j_range_ok_c;

  // Immediate fits when all bits above the format's sign bit replicate it
  always_comb begin
    i_range_ok_c = (&imm[31:11]) | ~(|imm[31:11]);
    b_range_ok_c = (&imm[31:12]) | ~(|imm[31:12]);
    j_range_ok_c = (&imm[31:20]) | ~(|imm[31:20]);
  end

  // Field packing per instruction format; unknown op_type yields a flagged NOP
  always_comb begin
    enc_instr_c = NOP_WORD;
    enc_err_c   = 1'b1;
    case (op_type)
      OP_LUI: begin
        enc_instr_c = {imm[31:12], rd, OPC_LUI};
        enc_err_c   = |imm[11:0];
      end
      OP_AUIPC: begin
        enc_instr_c = {imm[31:12], rd, OPC_AUIPC};
        enc_err_c   = |imm[11:0];
      end
      OP_JAL: begin
        enc_instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        enc_err_c   = imm[0] | ~j_range_ok_c;
      end
      OP_JALR: begin
        enc_instr_c = {imm[11:0], rs1, funct3, rd, OPC_JALR};
        enc_err_c   = ~i_range_ok_c;
      end
      OP_LOAD: begin
        enc_instr_c = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        enc_err_c   = ~i_range_ok_c;
      end
      OP_MISCMEM: begin
        enc_instr_c = {imm[11:0], rs1, funct3, rd, OPC_MISCMEM};
        enc_err_c   = ~i_range_ok_c;
      end
      OP_SYSTEM: begin
        enc_instr_c = {imm[11:0], rs1, funct3, rd, OPC_SYSTEM};
        enc_err_c   = ~i_range_ok_c;
      end
      OP_OPIMM: begin
        // Shift-immediates carry funct7 above a 5-bit shift amount
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          enc_instr_c = {funct7, imm[4:0], rs1, funct3, rd, OPC_OPIMM};
          enc_err_c   = |imm[31:5];
        end else begin
          enc_instr_c = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
          enc_err_c   = ~i_range_ok_c;
        end
      end
      OP_BRANCH: begin
        enc_instr_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        enc_err_c   = imm[0] | ~b_range_ok_c;
      end
      OP_STORE: begin
        enc_instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        enc_err_c   = ~i_range_ok_c;
      end
      OP_OP: begin
        enc_instr_c = {funct7, rs2, rs1, funct3, rd, OPC_OP};
        enc_err_c   = 1'b0;
      end
      default: begin
        enc_instr_c = NOP_WORD;
        enc_err_c   = 1'b1;
      end
    endcase
  end

  // FIFO: head entry drives the outputs directly, tail entry is the overflow slot
  enc_word_t         head_q, head_d;
  enc_word_t         tail_q, tail_d;
  logic              head_valid_q, head_valid_d;
  logic              tail_valid_q, tail_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push_c;
  logic              pop_c;
  enc_word_t         new_word_c;

  always_comb begin
    new_word_c   = '{instr: enc_instr_c, err: enc_err_c};
    push_c       = in_valid & in_ready_q;
    pop_c        = head_valid_q & out_ready;
    head_d       = head_q;
    tail_d       = tail_q;
    head_valid_d = head_valid_q;
    tail_valid_d = tail_valid_q;
    addr_d       = addr_q;
    if (clear) begin
      head_valid_d = 1'b0;
      tail_valid_d = 1'b0;
      addr_d       = BASE_ADDR;
    end else if (pop_c) begin
      addr_d = addr_q + ADDR_W'(ADDR_INC);
      // A push can't coincide with a pop while full since in_ready is low then
      if (tail_valid_q) begin
        head_d       = tail_q;
        tail_valid_d = 1'b0;
      end else if (push_c) begin
        head_d = new_word_c;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (push_c) begin
      if (!head_valid_q) begin
        head_d       = new_word_c;
        head_valid_d = 1'b1;
      end else begin
        tail_d       = new_word_c;
        tail_valid_d = 1'b1;
      end
    end
    in_ready_d = ~(head_valid_d & tail_valid_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      head_valid_q <= 1'b0;
      tail_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      addr_q       <= BASE_ADDR;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      head_valid_q <= head_valid_d;
      tail_valid_q <= tail_valid_d;
      in_ready_q   <= in_ready_d;
      addr_q       <= addr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = head_valid_q;
  assign instr     = head_q.instr;
  assign err       = head_q.err;
  assign out_addr  = addr_q;

endmodule
